jt7759_fetch: RTL and testbench

//  Byte fetch stage directly upstream of the ADPCM decoder. Reads sample

---
 rtl/jt7759_fetch_if.sv | 32 +++
 rtl/jt7759_fetch.sv | 169 ++++++++++++++++
 tb/tb_jt7759_fetch.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt7759_fetch_if.sv
// ---------------------------------------------------------------------------
// jt7759_fetch_if
// ROM read bus between the ADPCM byte fetcher and the sample ROM.
//   rom_cs    request, held high until the ROM acknowledges
//   rom_addr  byte address, stable while rom_cs is high
//   rom_data  byte returned by the ROM, valid with rom_ok
//   rom_ok    acknowledge, only meaningful while rom_cs is high
// modport master: the fetcher (drives cs/addr)
// modport slave : the ROM controller (drives data/ok)
// ---------------------------------------------------------------------------
interface jt7759_fetch_if #(
  parameter int AW = 17
);
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (
    output rom_cs,
    output rom_addr,
    input  rom_data,
    input  rom_ok
  );

  modport slave (
    input  rom_cs,
    input  rom_addr,
    output rom_data,
    output rom_ok
  );
endinterface

// File: rtl/jt7759_fetch.sv
// ---------------------------------------------------------------------------
// jt7759_fetch
// Byte fetch stage feeding the ADPCM decoder. Reads sample bytes from ROM,
// one request at a time, into a small show-ahead FIFO so the decoder can pop
// a byte whenever it needs one without waiting on ROM latency.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cen          qualifies rd only; everything else runs every clk
//   start        pulse: flush FIFO, clear underrun, fetch from start_addr
//   start_addr   first byte address for start
//   stop         pulse: flush FIFO, abandon request, go idle (beats start)
//   rd           pop request from the decoder
//   dout         FIFO head byte
//   dvalid       FIFO holds at least one byte
//   busy         fetch engine active
//   underrun     sticky flag: a pop was attempted on an empty FIFO
//   rom          ROM bus (master side)
// ---------------------------------------------------------------------------
module jt7759_fetch #(
  parameter int AW  = 17,
  parameter int DW2 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          stop,
  input  logic          rd,
  output logic [7:0]    dout,
  output logic          dvalid,
  output logic          busy,
  output logic          underrun,
  jt7759_fetch_if.master rom
);

  localparam int DEPTH = 2**DW2;
  localparam logic [DW2:0] CNT_ZERO = '0;
  localparam logic [DW2:0] CNT_ONE  = (DW2+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t         st;
  logic [7:0]     mem [DEPTH];
  logic [DW2-1:0] wr_ptr;
  logic [DW2-1:0] rd_ptr;
  logic [DW2:0]   count;

  logic           flush;
  logic           push;
  logic           pop;
  logic           pop_empty;
  logic           room;
  logic [DW2:0]   count_nx;
  logic [DW2-1:0] rd_ptr_nx;

  // ---- FIFO control: decide this clk's push/pop and the resulting fill ----
  always_comb begin
    flush     = start | stop;
    // a byte is only taken while our own request is up and no flush wins
    push      = (st == REQ) && rom.rom_cs && rom.rom_ok && !flush;
    pop       = rd && cen && (count != CNT_ZERO) && !flush;
    pop_empty = rd && cen && (count == CNT_ZERO);
    rd_ptr_nx = rd_ptr + 1'b1;
    count_nx  = count;
    if (flush)
      count_nx = CNT_ZERO;
    else if (push && !pop)
      count_nx = count + 1'b1;
    else if (pop && !push)
      count_nx = count - 1'b1;
    // count never exceeds DEPTH, so the MSB alone flags a full FIFO
    room = !count_nx[DW2];
  end

  // ---- FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rom.rom_data;
  end

  // ---- FIFO pointers, head register and status ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dvalid   <= 1'b0;
      dout     <= '0;
      underrun <= 1'b0;
    end else begin
      count  <= count_nx;
      dvalid <= (count_nx != CNT_ZERO);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr_nx;
        // Head register: the incoming byte becomes the head when the FIFO
        // is (or is about to be) empty, otherwise the next stored byte.
        // Popping the last byte leaves dout holding it.
        if (push && ((count == CNT_ZERO) || (pop && count == CNT_ONE)))
          dout <= rom.rom_data;
        else if (pop && count != CNT_ONE)
          dout <= mem[rd_ptr_nx];
      end
      if (start && !stop)
        underrun <= 1'b0;
      else if (pop_empty)
        underrun <= 1'b1;
    end
  end

  // ---- Fetch FSM: one outstanding ROM request at a time ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      busy         <= 1'b0;
      rom.rom_cs   <= 1'b0;
      rom.rom_addr <= '0;
    end else if (stop) begin
      st         <= IDLE;
      busy       <= 1'b0;
      rom.rom_cs <= 1'b0;
    end else if (start) begin
      st           <= REQ;
      busy         <= 1'b1;
      rom.rom_addr <= start_addr;
      // a live request is dropped for one clk so the ROM sees a fresh cs edge
      rom.rom_cs   <= !rom.rom_cs;
    end else begin
      case (st)
        IDLE: ;
        REQ: begin
          if (!rom.rom_cs)
            rom.rom_cs <= 1'b1;
          else if (rom.rom_ok) begin
            rom.rom_cs <= 1'b0;
            st         <= GAP;
          end
        end
        GAP: begin
          rom.rom_addr <= rom.rom_addr + 1'b1;
          if (room) begin
            rom.rom_cs <= 1'b1;
            st         <= REQ;
          end else
            st <= HOLD;
        end
        HOLD: begin
          if (room) begin
            rom.rom_cs <= 1'b1;
            st         <= REQ;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt7759_fetch.sv
// ---------------------------------------------------------------------------
// tb_jt7759_fetch
// Directed stimulus for the ROM byte fetcher. A ROM responder acknowledges
// each request after a programmable number of cycles (or on demand), and a
// queue-based reference of the byte stream is checked every cycle alongside
// hand-computed expectations for the interesting corners.
// ROM contents: byte at address a is a[7:0] ^ 8'hA5.
// ---------------------------------------------------------------------------
module tb_jt7759_fetch;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          rd = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [7:0]    dout;
  logic          dvalid;
  logic          busy;
  logic          underrun;

  logic          auto_ok = 1'b0;
  logic          man_ok = 1'b0;
  int            lat = 3;
  int            cs_cnt = 0;

  int            checks = 0;
  int            failures = 0;

  jt7759_fetch_if #(.AW(AW)) rom_if ();

  jt7759_fetch #(.AW(AW), .DW2(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .rd         (rd),
    .dout       (dout),
    .dvalid     (dvalid),
    .busy       (busy),
    .underrun   (underrun),
    .rom        (rom_if)
  );

  function automatic logic [7:0] romf(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  assign rom_if.rom_data = romf(rom_if.rom_addr);
  assign rom_if.rom_ok   = auto_ok | man_ok;

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ROM responder: ack arrives while cs has been seen high for 'lat' cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (rom_if.rom_cs) cs_cnt++;
    else cs_cnt = 0;
    auto_ok = rom_if.rom_cs && (cs_cnt == lat);
  end

  // Reference: queue of bytes the decoder should see, next expected address
  logic [7:0]    q[$];
  logic          m_und;
  logic          m_busy;
  logic          m_after_ok;
  logic [AW-1:0] exp_addr;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      m_und      = 1'b0;
      m_busy     = 1'b0;
      m_after_ok = 1'b0;
      exp_addr   = '0;
    end else begin
      logic acc;
      logic empty;
      chk("mon_dvalid", dvalid, q.size() != 0);
      if (q.size() != 0) chk("mon_dout", dout, q[0]);
      chk("mon_busy", busy, m_busy);
      chk("mon_underrun", underrun, m_und);
      if (!m_busy || m_after_ok) chk("mon_cs_low", rom_if.rom_cs, 0);
      if (rom_if.rom_cs) begin
        chk("mon_addr", rom_if.rom_addr, exp_addr);
        chk("mon_free_slot", q.size() < 4, 1);
      end
      acc        = rom_if.rom_cs && rom_if.rom_ok;
      empty      = (q.size() == 0);
      m_after_ok = 1'b0;
      if (rd && cen && empty && !(start && !stop)) m_und = 1'b1;
      if (stop) begin
        q.delete();
        m_busy = 1'b0;
      end else if (start) begin
        q.delete();
        m_und    = 1'b0;
        m_busy   = 1'b1;
        exp_addr = start_addr;
      end else begin
        if (rd && cen && !empty) void'(q.pop_front());
        if (acc) begin
          q.push_back(romf(exp_addr));
          exp_addr   = exp_addr + 1'b1;
          m_after_ok = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs_high(input string name, input int maxc);
    int n = 0;
    while (!rom_if.rom_cs && n < maxc) begin
      tick();
      n++;
    end
    chk(name, rom_if.rom_cs, 1);
  endtask

  task automatic wait_dvalid(input string name, input int maxc);
    int n = 0;
    while (!dvalid && n < maxc) begin
      tick();
      n++;
    end
    chk(name, dvalid, 1);
  endtask

  initial begin
    logic [7:0] d0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_cs", rom_if.rom_cs, 0);
    chk("rst_addr", rom_if.rom_addr, 0);
    rst_n = 1'b1;
    tick();

    // T2: fill from 0x100 with no reads
    start_addr = 17'h00100;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_cs_latency", rom_if.rom_cs, 1);
    chk("t2_first_addr", rom_if.rom_addr, 17'h00100);
    repeat (40) tick();
    chk("t2_hold_cs", rom_if.rom_cs, 0);
    chk("t2_dvalid", dvalid, 1);
    chk("t2_head", dout, 8'hA5);
    chk("t2_next_addr", rom_if.rom_addr, 17'h00104);
    chk("t2_busy", busy, 1);
    repeat (5) tick();
    chk("t2_hold_stays", rom_if.rom_cs, 0);

    // T3: one pop frees a slot; rd without cen does nothing
    rd = 1'b1; cen = 1'b1;
    tick();
    rd = 1'b0; cen = 1'b0;
    chk("t3_pop_head", dout, 8'hA4);
    chk("t3_dvalid", dvalid, 1);
    wait_cs_high("t3_req_issued", 5);
    chk("t3_req_addr", rom_if.rom_addr, 17'h00104);
    rd = 1'b1; cen = 1'b0;
    tick();
    rd = 1'b0;
    chk("t3_nocen_head", dout, 8'hA4);

    // T4: stall the ROM, drain, then pop on empty
    lat = 1000;
    cen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!dvalid) break;
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    chk("t4_drained", dvalid, 0);
    chk("t4_und_before", underrun, 0);
    d0 = dout;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t4_underrun", underrun, 1);
    chk("t4_dout_hold", dout, d0);
    repeat (3) tick();
    chk("t4_sticky", underrun, 1);

    // T5: restart mid-request at the top of ROM, address wraps
    lat = 3;
    start_addr = 17'h1FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_und_clear", underrun, 0);
    chk("t5_cs_drop", rom_if.rom_cs, 0);
    chk("t5_flushed", dvalid, 0);
    tick();
    chk("t5_cs_up", rom_if.rom_cs, 1);
    chk("t5_addr", rom_if.rom_addr, 17'h1FFFF);
    wait_dvalid("t5_byte_arrives", 10);
    chk("t5_byte", dout, 8'h5A);
    wait_cs_high("t5_second_req", 10);
    chk("t5_wrap", rom_if.rom_addr, 17'h00000);

    // T6: start coinciding with rom_ok discards the byte
    lat = 1000;
    start_addr = 17'h00200;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_cs_high("t6_req_up", 5);
    start_addr = 17'h00300;
    start = 1'b1;
    man_ok = 1'b1;
    tick();
    start = 1'b0;
    man_ok = 1'b0;
    chk("t6_empty", dvalid, 0);
    chk("t6_cs_drop", rom_if.rom_cs, 0);
    tick();
    chk("t6_cs_up", rom_if.rom_cs, 1);
    chk("t6_addr", rom_if.rom_addr, 17'h00300);
    repeat (2) tick();
    chk("t6_still_empty", dvalid, 0);
    start_addr = 17'h00050;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t6_stop_busy", busy, 0);
    chk("t6_stop_cs", rom_if.rom_cs, 0);
    repeat (3) tick();
    chk("t6_idle_stays", rom_if.rom_cs, 0);

    // T1: asynchronous reset in the middle of a request
    lat = 3;
    start_addr = 17'h00400;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_dvalid("t1_have_data", 10);
    wait_cs_high("t1_req_up", 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_dout", dout, 0);
    chk("t1_dvalid", dvalid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_underrun", underrun, 0);
    chk("t1_cs", rom_if.rom_cs, 0);
    chk("t1_addr", rom_if.rom_addr, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t1_idle_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
